hello_display_scan: RTL and testbench



---
 rtl/hello_display_scan.sv | 97 +++++++++
 tb/tb_hello_display_scan.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hello_display_scan.sv
// hello_display_scan: frame-synchronous 8-digit multiplexed 7-segment driver.
// Words are staged on Load and promoted to the display only at frame end.
module hello_display_scan #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Data,
  input  logic        Load,
  output logic        Ack,
  output logic        Pending,
  output logic [6:0]  Seg,
  output logic [7:0]  Digit_n,
  output logic        Frame_sync
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  typedef enum logic {
    BLANK,
    SHOW
  } phase_t;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   staging;
  logic [31:0]   disp;
  logic          pending;
  logic          ack;
  logic          frame_end;
  phase_t        phase;
  logic [3:0]    code;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h1:       s = 7'h09;
      4'h2:       s = 7'h06;
      4'h3, 4'h4: s = 7'h47;
      4'h5:       s = 7'h40;
      4'h0, 4'h6,
      4'h7, 4'h8: s = 7'h7F;
      default:    s = 7'h3F;
    endcase
    return s;
  endfunction

  assign frame_end = (cnt == CNT_MAX) && (idx == 3'd7);

  // Slot counter, staging capture and frame-boundary promotion.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt     <= '0;
      idx     <= '0;
      staging <= '0;
      disp    <= '0;
      pending <= 1'b0;
      ack     <= 1'b0;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      ack <= frame_end && pending;
      if (frame_end && pending)
        disp <= staging;
      if (Load) begin
        staging <= Data;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // Phase and segment drive derived from registered state only.
  always_comb begin
    phase = (cnt < CNT_BLANK) ? BLANK : SHOW;
    code  = disp[{idx, 2'b00} +: 4];
    Seg     = 7'h7F;
    Digit_n = 8'hFF;
    if (phase == SHOW) begin
      Seg     = decode(code);
      Digit_n = ~(8'd1 << idx);
    end
  end

  assign Frame_sync = (idx == 3'd0) && (cnt == '0);
  assign Ack        = ack;
  assign Pending    = pending;

endmodule

// File: tb/tb_hello_display_scan.sv
// tb_hello_display_scan: directed checks of scan, staging and decode.
// TICK_DIV=4, BLANK_CYC=1: a frame is 32 cycles.
module tb_hello_display_scan;

  logic        Clock;
  logic        Reset;
  logic [31:0] Data;
  logic        Load;
  logic        Ack;
  logic        Pending;
  logic [6:0]  Seg;
  logic [7:0]  Digit_n;
  logic        Frame_sync;

  int checks;
  int failures;
  int t;

  hello_display_scan #(
    .TICK_DIV (4),
    .BLANK_CYC(1)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Data      (Data),
    .Load      (Load),
    .Ack       (Ack),
    .Pending   (Pending),
    .Seg       (Seg),
    .Digit_n   (Digit_n),
    .Frame_sync(Frame_sync)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  function automatic logic [7:0] exp_dn(input int tt);
    logic [7:0] one;
    one = 8'd1;
    if (tt % 4 == 0) return 8'hFF;
    return ~(one << ((tt / 4) % 8));
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    Load  = 1'b0;
    Data  = '0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    t = 0;
    checks++;
    if (Digit_n !== 8'hFF || Seg !== 7'h7F || Frame_sync !== 1'b1) begin
      failures++;
      $display("FAIL reset_out: dn=%h seg=%h fs=%b want FF 7F 1",
               Digit_n, Seg, Frame_sync);
    end
    checks++;
    if (Pending !== 1'b0 || Ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: pend=%b ack=%b want 0 0", Pending, Ack);
    end
    Reset = 1'b0;
  endtask

  task automatic test_scan();
    for (int k = 0; k < 40; k++) begin
      step();
      checks++;
      if (Digit_n !== exp_dn(t)) begin
        failures++;
        $display("FAIL scan_dn t=%0d: got %h want %h", t, Digit_n, exp_dn(t));
      end
      checks++;
      if (Seg !== 7'h7F || Ack !== 1'b0) begin
        failures++;
        $display("FAIL scan_seg t=%0d: seg=%h ack=%b want 7F 0", t, Seg, Ack);
      end
      checks++;
      if (Frame_sync !== (t % 32 == 0)) begin
        failures++;
        $display("FAIL scan_fs t=%0d: got %b want %b", t, Frame_sync,
                 (t % 32 == 0));
      end
    end
  endtask

  task automatic test_load();
    logic [6:0] want [8];
    want = '{7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h47, 7'h47, 7'h06, 7'h09};
    run_to(40);
    Data = 32'h12345000;
    Load = 1'b1;
    step();
    Load = 1'b0;
    while (t < 64) begin
      checks++;
      if (Pending !== 1'b1 || Ack !== 1'b0) begin
        failures++;
        $display("FAIL load_wait t=%0d: pend=%b ack=%b want 1 0",
                 t, Pending, Ack);
      end
      step();
    end
    checks++;
    if (Ack !== 1'b1 || Pending !== 1'b0) begin
      failures++;
      $display("FAIL load_ack: ack=%b pend=%b want 1 0", Ack, Pending);
    end
    while (t < 96) begin
      step();
      if (t < 96 && t % 4 != 0) begin
        checks++;
        if (Seg !== want[(t / 4) % 8] || Ack !== 1'b0) begin
          failures++;
          $display("FAIL load_seg t=%0d: seg=%h ack=%b want %h 0",
                   t, Seg, Ack, want[(t / 4) % 8]);
        end
      end
    end
  endtask

  task automatic test_overwrite();
    int acks;
    acks = 0;
    Data = 32'hAAAA_AAAA;
    Load = 1'b1;
    step();
    Load = 1'b0;
    run_to(100);
    Data = 32'h0000_0011;
    Load = 1'b1;
    step();
    Load = 1'b0;
    while (t < 160) begin
      if (Ack === 1'b1) acks++;
      if (t > 128 && t % 4 != 0) begin
        checks++;
        if (Seg !== (((t / 4) % 8) < 2 ? 7'h09 : 7'h7F)) begin
          failures++;
          $display("FAIL ovr_seg t=%0d: got %h want %h", t, Seg,
                   (((t / 4) % 8) < 2 ? 7'h09 : 7'h7F));
        end
      end
      step();
    end
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL ovr_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_back_to_back();
    run_to(170);
    Data = 32'h1;
    Load = 1'b1;
    step();
    Load = 1'b0;
    run_to(191);
    Data = 32'h5;
    Load = 1'b1;
    step();
    Load = 1'b0;
    checks++;
    if (Ack !== 1'b1 || Pending !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ack1: ack=%b pend=%b want 1 1", Ack, Pending);
    end
    step();
    checks++;
    if (Seg !== 7'h09 || Ack !== 1'b0) begin
      failures++;
      $display("FAIL b2b_h: seg=%h ack=%b want 09 0", Seg, Ack);
    end
    run_to(224);
    checks++;
    if (Ack !== 1'b1 || Pending !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ack2: ack=%b pend=%b want 1 0", Ack, Pending);
    end
    step();
    checks++;
    if (Seg !== 7'h40) begin
      failures++;
      $display("FAIL b2b_o: got %h want 40", Seg);
    end
  endtask

  task automatic test_mid_reset();
    run_to(230);
    Data = 32'h1111_1111;
    Load = 1'b1;
    step();
    Load = 1'b0;
    run_to(246);
    checks++;
    if (Pending !== 1'b1 || Digit_n !== 8'hDF) begin
      failures++;
      $display("FAIL mid_pre: pend=%b dn=%h want 1 DF", Pending, Digit_n);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    t = 0;
    checks++;
    if (Digit_n !== 8'hFF || Seg !== 7'h7F || Pending !== 1'b0 ||
        Frame_sync !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst: dn=%h seg=%h pend=%b fs=%b want FF 7F 0 1",
               Digit_n, Seg, Pending, Frame_sync);
    end
    step();
    checks++;
    if (Digit_n !== 8'hFE) begin
      failures++;
      $display("FAIL mid_restart: got %h want FE", Digit_n);
    end
    while (t < 33) begin
      checks++;
      if (Seg !== 7'h7F || Ack !== 1'b0) begin
        failures++;
        $display("FAIL mid_disp0 t=%0d: seg=%h ack=%b want 7F 0",
                 t, Seg, Ack);
      end
      step();
    end
  endtask

  task automatic test_error_codes();
    int lows;
    Data = 32'hFEDC_BA98;
    Load = 1'b1;
    step();
    Load = 1'b0;
    run_to(64);
    checks++;
    if (Ack !== 1'b1) begin
      failures++;
      $display("FAIL err_ack: got %b want 1", Ack);
    end
    while (t < 96) begin
      lows = 0;
      for (int b = 0; b < 8; b++) if (Digit_n[b] === 1'b0) lows++;
      checks++;
      if (lows > 1) begin
        failures++;
        $display("FAIL err_onehot t=%0d: dn=%h", t, Digit_n);
      end
      if (t % 4 != 0) begin
        checks++;
        if (Seg !== (((t / 4) % 8) == 0 ? 7'h7F : 7'h3F)) begin
          failures++;
          $display("FAIL err_seg t=%0d: got %h want %h", t, Seg,
                   (((t / 4) % 8) == 0 ? 7'h7F : 7'h3F));
        end
      end
      step();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    t        = 0;
    test_reset();
    test_scan();
    test_load();
    test_overwrite();
    test_back_to_back();
    test_mid_reset();
    test_error_codes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
